// File: rtl/cpu_record_decoder.sv
// Extracts time, PC, destination and data fields from the trace character stream.
// Optional alignment flag on rec_misalign is compiled in with CPU_REC_ALIGN_CHECK_EN.
module cpu_record_decoder (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  char,
  input  logic [1:0]  format_type,
  output logic        rec_valid,
  output logic [1:0]  rec_type,
  output logic [13:0] rec_time,
  output logic [31:0] rec_pc,
  output logic [31:0] rec_dst,
  output logic [31:0] rec_data,
  output logic [15:0] rec_count,
  output logic        rec_misalign
);

  localparam int unsigned TIME_W  = 14;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned COUNT_W = 16;

  typedef enum logic [3:0] {
    S_IDLE, S_TIME, S_PC, S_SEP, S_REG, S_ADDR, S_ARROW, S_DATA, S_DONE
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [TIME_W-1:0]   r_acc_time, w_time_nxt;
  logic [WORD_W-1:0]   r_acc_pc, w_pc_nxt;
  logic [WORD_W-1:0]   r_acc_dst, w_dst_nxt;
  logic [WORD_W-1:0]   r_acc_data, w_data_nxt;
  logic                r_data_seen, w_seen_nxt;

  logic                r_valid;
  logic [1:0]          r_type;
  logic [TIME_W-1:0]   r_time;
  logic [WORD_W-1:0]   r_pc, r_dst, r_data;
  logic [COUNT_W-1:0]  r_count;

  logic                w_is_dig, w_is_hex, w_rec_done;
  logic [3:0]          w_nib;
  logic [TIME_W-1:0]   w_time_mac;
  logic [WORD_W-1:0]   w_dst_mac;

  // Character classification: decimal digits and lowercase hex only
  assign w_is_dig   = (char >= "0") && (char <= "9");
  assign w_is_hex   = w_is_dig || ((char >= "a") && (char <= "f"));
  assign w_nib      = w_is_dig ? char[3:0] : (char[3:0] + 4'd9);
  assign w_rec_done = (format_type == 2'b01) || (format_type == 2'b10);

  // acc*10 + d as shift-add, wrapping at the accumulator width
  assign w_time_mac = {r_acc_time[TIME_W-4:0], 3'b000} + {r_acc_time[TIME_W-2:0], 1'b0}
                    + {{(TIME_W-4){1'b0}}, w_nib};
  assign w_dst_mac  = {r_acc_dst[WORD_W-4:0], 3'b000} + {r_acc_dst[WORD_W-2:0], 1'b0}
                    + {{(WORD_W-4){1'b0}}, w_nib};

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_acc_time  <= '0;
      r_acc_pc    <= '0;
      r_acc_dst   <= '0;
      r_acc_data  <= '0;
      r_data_seen <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_acc_time  <= w_time_nxt;
      r_acc_pc    <= w_pc_nxt;
      r_acc_dst   <= w_dst_nxt;
      r_acc_data  <= w_data_nxt;
      r_data_seen <= w_seen_nxt;
    end
  end

  always_comb begin
    w_state_nxt = S_IDLE;
    w_time_nxt  = r_acc_time;
    w_pc_nxt    = r_acc_pc;
    w_dst_nxt   = r_acc_dst;
    w_data_nxt  = r_acc_data;
    w_seen_nxt  = r_data_seen;
    if (char == "^") begin
      w_state_nxt = S_TIME;
      w_time_nxt  = '0;
      w_pc_nxt    = '0;
      w_dst_nxt   = '0;
      w_data_nxt  = '0;
      w_seen_nxt  = 1'b0;
    end else begin
      case (r_state)
        S_TIME: begin
          if (w_is_dig) begin
            w_time_nxt  = w_time_mac;
            w_state_nxt = S_TIME;
          end else if (char == "@") w_state_nxt = S_PC;
        end
        S_PC: begin
          if (w_is_hex) begin
            w_pc_nxt    = {r_acc_pc[WORD_W-5:0], w_nib};
            w_state_nxt = S_PC;
          end else if (char == ":") w_state_nxt = S_SEP;
        end
        S_SEP: begin
          if (char == " ")      w_state_nxt = S_SEP;
          else if (char == "$") w_state_nxt = S_REG;
          else if (char == "*") w_state_nxt = S_ADDR;
        end
        S_REG: begin
          if (w_is_dig) begin
            w_dst_nxt   = w_dst_mac;
            w_state_nxt = S_REG;
          end else if ((char == " ") || (char == "<")) w_state_nxt = S_ARROW;
        end
        S_ADDR: begin
          if (w_is_hex) begin
            w_dst_nxt   = {r_acc_dst[WORD_W-5:0], w_nib};
            w_state_nxt = S_ADDR;
          end else if ((char == " ") || (char == "<")) w_state_nxt = S_ARROW;
        end
        S_ARROW: begin
          if ((char == " ") || (char == "<")) w_state_nxt = S_ARROW;
          else if (char == "=")               w_state_nxt = S_DATA;
        end
        S_DATA: begin
          // Leading blanks are allowed only before the first data digit
          if ((char == " ") && !r_data_seen) w_state_nxt = S_DATA;
          else if (w_is_hex) begin
            w_data_nxt  = {r_acc_data[WORD_W-5:0], w_nib};
            w_seen_nxt  = 1'b1;
            w_state_nxt = S_DATA;
          end else if (char == "#") w_state_nxt = S_DONE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Record capture, qualified solely by the checker's verdict
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_type  <= '0;
      r_time  <= '0;
      r_pc    <= '0;
      r_dst   <= '0;
      r_data  <= '0;
      r_count <= '0;
    end else if (w_rec_done) begin
      r_valid <= 1'b1;
      r_type  <= format_type;
      r_time  <= r_acc_time;
      r_pc    <= r_acc_pc;
      r_dst   <= r_acc_dst;
      r_data  <= r_acc_data;
      if (r_count != {COUNT_W{1'b1}}) r_count <= r_count + COUNT_W'(1);
    end else begin
      r_valid <= 1'b0;
    end
  end

`ifdef CPU_REC_ALIGN_CHECK_EN
  logic r_misalign;

  always_ff @(posedge clk) begin
    if (!reset)          r_misalign <= 1'b0;
    else if (w_rec_done) r_misalign <= (r_acc_pc[1:0] != 2'b00) ||
                                       ((format_type == 2'b10) && (r_acc_dst[1:0] != 2'b00));
  end

  assign rec_misalign = r_misalign;
`else
  assign rec_misalign = 1'b0;
`endif

  assign rec_valid = r_valid;
  assign rec_type  = r_type;
  assign rec_time  = r_time;
  assign rec_pc    = r_pc;
  assign rec_dst   = r_dst;
  assign rec_data  = r_data;
  assign rec_count = r_count;

endmodule

// File: tb/tb_cpu_record_decoder.sv
// Scoreboard bench for cpu_record_decoder: stimulus pushes expected records, a negedge monitor pops and checks.
module tb_cpu_record_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  char;
  logic [1:0]  format_type;
  logic        rec_valid;
  logic [1:0]  rec_type;
  logic [13:0] rec_time;
  logic [31:0] rec_pc, rec_dst, rec_data;
  logic [15:0] rec_count;
  logic        rec_misalign;

  cpu_record_decoder dut (
    .clk(clk), .reset(reset), .char(char), .format_type(format_type),
    .rec_valid(rec_valid), .rec_type(rec_type), .rec_time(rec_time),
    .rec_pc(rec_pc), .rec_dst(rec_dst), .rec_data(rec_data),
    .rec_count(rec_count), .rec_misalign(rec_misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  typ;
    logic [13:0] tim;
    logic [31:0] pc;
    logic [31:0] dst;
    logic [31:0] data;
    logic [15:0] cnt;
    logic        mis;
  } exp_t;

  exp_t        q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] exp_count = 16'd0;
  bit          bulk = 1'b0;
  int          bulk_strobes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input logic [7:0] c, input logic [1:0] ft);
    char        = c;
    format_type = ft;
    @(posedge clk);
    #1;
  endtask

  task automatic send_str(input string s, input int start);
    for (int i = start; i < s.len(); i++) tick(s[i], 2'b00);
  endtask

  task automatic push_exp(input logic [1:0] typ, input logic [13:0] tim, input logic [31:0] pc,
                          input logic [31:0] dst, input logic [31:0] data);
    exp_t e;
    if (exp_count != 16'hffff) exp_count = exp_count + 16'd1;
    e.typ = typ; e.tim = tim; e.pc = pc; e.dst = dst; e.data = data; e.cnt = exp_count;
`ifdef CPU_REC_ALIGN_CHECK_EN
    e.mis = (pc[1:0] != 2'b00) || ((typ == 2'b10) && (dst[1:0] != 2'b00));
`else
    e.mis = 1'b0;
`endif
    q.push_back(e);
  endtask

  task automatic chk_reset_state();
    chk("reset_valid", 32'(rec_valid), 32'd0);
    chk("reset_type",  32'(rec_type),  32'd0);
    chk("reset_time",  32'(rec_time),  32'd0);
    chk("reset_pc",    rec_pc,         32'd0);
    chk("reset_dst",   rec_dst,        32'd0);
    chk("reset_data",  rec_data,       32'd0);
    chk("reset_count", 32'(rec_count), 32'd0);
    chk("reset_mis",   32'(rec_misalign), 32'd0);
  endtask

  // Monitor: every strobe must match the oldest expected record
  always @(negedge clk) begin
    if (rec_valid === 1'b1) begin
      if (bulk) bulk_strobes++;
      else if (q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_strobe: got rec_valid=1 expected no record (time=%0d)", rec_time);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("rec_type",  32'(rec_type),     32'(e.typ));
        chk("rec_time",  32'(rec_time),     32'(e.tim));
        chk("rec_pc",    rec_pc,            e.pc);
        chk("rec_dst",   rec_dst,           e.dst);
        chk("rec_data",  rec_data,          e.data);
        chk("rec_count", 32'(rec_count),    32'(e.cnt));
        chk("rec_mis",   32'(rec_misalign), 32'(e.mis));
      end
    end
  end

  initial begin
    reset = 1'b0;
    char = 8'h20;
    format_type = 2'b00;
    repeat (3) tick(" ", 2'b00);
    reset = 1'b1;
    tick(" ", 2'b00);
    chk_reset_state();

    // Register record
    send_str("^12@00003004: $5 <= 0000abcd#", 0);
    push_exp(2'b01, 14'd12, 32'h3004, 32'd5, 32'h0000abcd);
    tick(" ", 2'b01);
    tick(" ", 2'b00);
    chk("strobe_one_cycle", 32'(rec_valid), 32'd0);

    // Memory record
    send_str("^9999@0000300c: *00001002 <=ffffffff#", 0);
    push_exp(2'b10, 14'd9999, 32'h300c, 32'h1002, 32'hffffffff);
    tick(" ", 2'b10);
    tick(" ", 2'b00);

    // Malformed record: checker reports nothing, outputs must hold
    send_str("^1@0000300: $1 <= 00000001#", 0);
    tick(" ", 2'b00);
    tick(" ", 2'b00);
    // format_type 11 must be ignored
    tick(" ", 2'b11);
    tick(" ", 2'b00);
    chk("hold_valid", 32'(rec_valid), 32'd0);
    chk("hold_type",  32'(rec_type),  32'd2);
    chk("hold_time",  32'(rec_time),  32'd9999);
    chk("hold_pc",    rec_pc,         32'h300c);
    chk("hold_dst",   rec_dst,        32'h1002);
    chk("hold_data",  rec_data,       32'hffffffff);
    chk("hold_count", 32'(rec_count), 32'd2);

    // Back-to-back: next '^' coincides with the completion flag; time wraps mod 2^14
    send_str("^3@00000010: $31 <= 12345678#", 0);
    push_exp(2'b01, 14'd3, 32'h10, 32'd31, 32'h12345678);
    tick("^", 2'b01);
    send_str("^16385@deadbeef: *0000abcd <=00000042#", 1);
    push_exp(2'b10, 14'd1, 32'hdeadbeef, 32'h0000abcd, 32'h42);
    tick(" ", 2'b10);
    tick(" ", 2'b00);

    // Reset mid-PC field discards the partial record
    send_str("^5@00ab", 0);
    reset = 1'b0;
    tick(" ", 2'b00);
    tick(" ", 2'b00);
    reset = 1'b1;
    exp_count = 16'd0;
    chk_reset_state();
    // 9-digit PC keeps only the last 8 nibbles
    send_str("^42@100000004: $10 <=0000ffff#", 0);
    push_exp(2'b01, 14'd42, 32'h4, 32'd10, 32'h0000ffff);
    tick(" ", 2'b01);
    tick(" ", 2'b00);

    // Saturation: preload the counter with bare completion flags
    bulk = 1'b1;
    for (int i = 0; i < 65533; i++) begin
      tick(" ", 2'b01);
      if (exp_count != 16'hffff) exp_count = exp_count + 16'd1;
    end
    tick(" ", 2'b00);
    bulk = 1'b0;
    chk("bulk_strobes", 32'(bulk_strobes), 32'd65533);
    chk("bulk_count",   32'(rec_count),    32'd65534);
    send_str("^0@00000000: $0 <=0#", 0);
    push_exp(2'b01, 14'd0, 32'h0, 32'd0, 32'h0);
    tick(" ", 2'b01);
    tick(" ", 2'b00);
    send_str("^7@00000002: *00000008 <= 00000001#", 0);
    push_exp(2'b10, 14'd7, 32'h2, 32'h8, 32'h1);
    tick(" ", 2'b10);
    repeat (4) tick(" ", 2'b00);

    chk("sat_count",     32'(rec_count), 32'hffff);
    chk("queue_drained", 32'(q.size()),  32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_record_decoder.md
# cpu_record_decoder

Downstream companion of the CPU trace-string format checker. Samples the same character stream and extracts the fields of each trace record into binary values: time, PC, register number or memory address, and write data. Emits a one-cycle record strobe only when the checker flags the record as well-formed. Feeds the trace comparator / scoreboard stage.

## Interface
Parameters:
- none (all widths fixed by the trace format)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-low reset (reset==0 clears the block on a clk edge)
- char  input  8  ASCII character, one per cycle; the same stream driven into the checker
- format_type  input  2  checker output: 01 = register record complete, 10 = memory record complete, 00/11 = none
- rec_valid  output  1  one-cycle strobe: record fields valid
- rec_type  output  2  01 register write, 10 memory write
- rec_time  output  14  decimal time field, binary
- rec_pc  output  32  hex PC field
- rec_dst  output  32  register number (decimal, zero-extended) or memory address (hex)
- rec_data  output  32  hex write data
- rec_count  output  16  number of records emitted, saturates at 16'hffff
- rec_misalign  output  1  only with CPU_REC_ALIGN_CHECK_EN, see Configuration

## Operation
- Field FSM states: IDLE, TIME, PC, SEP, REG, ADDR, ARROW, DATA, DONE. It is lenient; validity comes only from format_type.
- Any state, char=='^': clear all accumulators, go to TIME. This overrides every rule below.
- TIME: digit -> acc_time = acc_time*10 + d (mod 2^14, shift-add); '@' -> PC.
- PC: hex digit (0-9, a-f lowercase) -> acc_pc = {acc_pc[27:0], h}; ':' -> SEP.
- SEP: ' ' stays; '$' -> REG; '*' -> ADDR.
- REG: digit -> acc_dst = acc_dst*10 + d; ' ' or '<' -> ARROW.
- ADDR: hex -> acc_dst = {acc_dst[27:0], h}; ' ' or '<' -> ARROW.
- ARROW: ' ' and '<' stay; '=' -> DATA.
- DATA: ' ' stays while acc_data untouched; hex -> acc_data shift-in; '#' -> DONE.
- DONE: hold accumulators; the next non-'^' char -> IDLE.
- Any char not listed for the current state -> IDLE. Accumulators hold their values in IDLE.
- Output update when format_type is 01 or 10 at a clk edge:
  - register pre-edge acc_time, acc_pc, acc_dst and acc_data, plus format_type, into the rec_* outputs;
  - rec_valid <= 1;
  - rec_count increments unless it is ffff.
- Otherwise rec_valid <= 0; rec_type, rec_time, rec_pc, rec_dst and rec_data hold their last values.
- format_type 11 is treated as 00.

## Timing
- Reset: every output 0; FSM in IDLE; accumulators 0. Reset mid-record discards the partial record; no strobe is emitted for it.
- Latency:
  - '#' sampled at edge N;
  - the checker drives format_type nonzero during cycle N..N+1;
  - the decoder samples it at edge N+1;
  - rec_valid is high for exactly one cycle after edge N+1.
- Simultaneous events: if the char at edge N+1 is '^', the outputs still capture the finished record (pre-edge accumulator values) and the accumulators clear in the same edge. Back-to-back records are lossless at one char per cycle.
- No back-pressure; the consumer must accept every strobe.

## Configuration
- CPU_REC_ALIGN_CHECK_EN defined:
  - rec_misalign is registered together with rec_valid;
  - it is 1 if rec_pc[1:0]!=0, or if rec_type==10 and rec_dst[1:0]!=0;
  - it holds with the other rec_* outputs; reset value 0.
- Not defined: the port exists but is tied to 0; no alignment logic is compiled.

## Test plan
- Register record: "^12@00003004: $5 <= 0000abcd#", then ' ' -> rec_valid for one cycle at edge N+1; type 01, time 12, pc 32'h3004, dst 5, data 32'h0000abcd, count 1.
- Memory record: "^9999@0000300c: *00001002 <=ffffffff#" -> type 10, time 9999, dst 32'h1002, data 32'hffffffff. rec_misalign=1 with the macro, 0 without it.
- Malformed: 7-hex-digit PC "^1@0000300: $1 <= 00000001#" -> checker gives 00, no rec_valid, count unchanged, outputs hold their previous values.
- Back-to-back: a second record's '^' arrives at edge N+1 of the first -> first record captured intact, second decoded correctly, count 2.
- Reset low asserted mid-PC field, then released and a valid record sent -> no strobe for the aborted record; the new record decodes correctly; count restarts at 1.
- Saturation: preload via 65535 records (or force), send one more valid record -> rec_count stays 16'hffff; rec_valid still pulses.
